// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath.
// It fetches an opcode byte and an optional immediate byte, then drives the regfile, MUX and ALU controls for one execute cycle.
module control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] INSTR,
  input  logic       INSTR_VALID,
  input  logic       ALU_ZERO,
  input  logic       ALU_CARRY,
  output logic       MEM_REQ,
  output logic [7:0] PC,
  output logic [1:0] RA_ADDR,
  output logic [1:0] RB_ADDR,
  output logic       MUX_SEL,
  output logic [7:0] IMM,
  output logic [1:0] ALU_OP,
  output logic       WB_SEL,
  output logic       REG_WE,
  output logic       Z_FLAG,
  output logic       C_FLAG,
  output logic       HALTED
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_FETCH_IMM,
    S_EXECUTE,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_LDI  = 3'b100,
    OP_JZ   = 3'b101,
    OP_JMP  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] ir;
  opcode_t    op;
  opcode_t    instr_op;
  logic       is_alu;

  // LDI/JZ/JMP always carry an immediate; ALU ops carry one only when the I-bit is set.
  function automatic logic needs_imm(input opcode_t code, input logic ibit);
    case (code)
      OP_LDI, OP_JZ, OP_JMP: needs_imm = 1'b1;
      OP_HALT:               needs_imm = 1'b0;
      default:               needs_imm = ibit;
    endcase
  endfunction

  assign op       = opcode_t'(ir[7:5]);
  assign instr_op = opcode_t'(INSTR[7:5]);
  assign is_alu   = ~ir[7];

  assign RA_ADDR = ir[3:2];
  assign RB_ADDR = ir[1:0];
  assign ALU_OP  = ir[6:5];

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      S_FETCH: begin
        if (INSTR_VALID) begin
          if (instr_op == OP_HALT)            state_next = S_HALT;
          else if (needs_imm(instr_op, INSTR[4])) state_next = S_FETCH_IMM;
          else                                 state_next = S_EXECUTE;
        end
      end
      S_FETCH_IMM: if (INSTR_VALID) state_next = S_EXECUTE;
      S_EXECUTE:   state_next = S_FETCH;
      S_HALT:      state_next = S_HALT;
    endcase
  end

  // Datapath registers: PC, IR, immediate and the latched ALU flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC     <= RESET_PC;
      ir     <= '0;
      IMM    <= '0;
      Z_FLAG <= 1'b0;
      C_FLAG <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (INSTR_VALID) begin
            ir <= INSTR;
            PC <= PC + 8'd1;
          end
        end
        S_FETCH_IMM: begin
          if (INSTR_VALID) begin
            IMM <= INSTR;
            PC  <= PC + 8'd1;
          end
        end
        S_EXECUTE: begin
          if (is_alu) begin
            Z_FLAG <= ALU_ZERO;
            C_FLAG <= ALU_CARRY;
          end else if (op == OP_JMP || (op == OP_JZ && Z_FLAG)) begin
            PC <= IMM;
          end
        end
        S_HALT: ;
      endcase
    end
  end

  always_comb begin
    MEM_REQ = 1'b0;
    REG_WE  = 1'b0;
    WB_SEL  = 1'b0;
    MUX_SEL = 1'b0;
    HALTED  = 1'b0;
    unique case (state)
      S_FETCH, S_FETCH_IMM: MEM_REQ = 1'b1;
      S_EXECUTE: begin
        if (is_alu) begin
          REG_WE  = 1'b1;
          MUX_SEL = ir[4];
        end else if (op == OP_LDI) begin
          REG_WE = 1'b1;
          WB_SEL = 1'b1;
        end
      end
      S_HALT: HALTED = 1'b1;
    endcase
  end

endmodule
